// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequences one ALU operation at a time through a
// 16x16 register file. Each operation reads its operands, hands them to an
// external combinational ALU, captures the result and flags, then writes
// the result back and updates the status register.
// Latency: accept at T, done at T+3, ready again at T+4.
module alu_exec_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_opcode,
   input  logic [3:0]  req_rdest,
   input  logic [3:0]  req_rsrc,
   input  logic [7:0]  req_imm,
   input  logic        req_use_imm,
   input  logic        req_imm_sext,
   input  logic        req_wb_en,
   input  logic        req_flags_we,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [7:0]  alu_opcode,
   input  logic [15:0] alu_c,
   input  logic [4:0]  alu_flags,
   output logic [4:0]  psr,
   output logic        done,
   input  logic [3:0]  dbg_sel,
   output logic [15:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, OPER, EXEC, WB} state_t;

   state_t      state_reg;

   // Request fields captured at acceptance; the request bus is ignored
   // until the FSM returns to IDLE.
   logic [7:0]  opcode_reg;
   logic [3:0]  rdest_reg;
   logic [3:0]  rsrc_reg;
   logic [7:0]  imm_reg;
   logic        use_imm_reg;
   logic        imm_sext_reg;
   logic        wb_en_reg;
   logic        flags_we_reg;

   // ALU outputs captured at the end of EXEC.
   logic [15:0] result_reg;
   logic [4:0]  flags_reg;

   logic [15:0] regfile [16];
   logic [15:0] imm_ext;
   logic [15:0] reg_we;

   assign imm_ext   = imm_sext_reg ? {{8{imm_reg[7]}}, imm_reg} : {8'h00, imm_reg};
   assign req_ready = (state_reg == IDLE);

   // Debug read is asynchronous, so during WB it still shows the old value.
   assign dbg_data  = regfile[dbg_sel];

   // Per-register write strobe: only in WB, only for the latched destination.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_we
         assign reg_we[gi] = (state_reg == WB) && wb_en_reg && (rdest_reg == gi);
      end
   endgenerate

   // Register file: cleared on reset, written with the captured result in WB.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            regfile[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (reg_we[i]) begin
               regfile[i] <= result_reg;
            end
         end
      end
   end

   // Control FSM with registered ALU operands, PSR and done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         opcode_reg   <= 8'h00;
         rdest_reg    <= 4'h0;
         rsrc_reg     <= 4'h0;
         imm_reg      <= 8'h00;
         use_imm_reg  <= 1'b0;
         imm_sext_reg <= 1'b0;
         wb_en_reg    <= 1'b0;
         flags_we_reg <= 1'b0;
         result_reg   <= 16'h0000;
         flags_reg    <= 5'b00000;
         alu_a        <= 16'h0000;
         alu_b        <= 16'h0000;
         alu_opcode   <= 8'h00;
         psr          <= 5'b00000;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  opcode_reg   <= req_opcode;
                  rdest_reg    <= req_rdest;
                  rsrc_reg     <= req_rsrc;
                  imm_reg      <= req_imm;
                  use_imm_reg  <= req_use_imm;
                  imm_sext_reg <= req_imm_sext;
                  wb_en_reg    <= req_wb_en;
                  flags_we_reg <= req_flags_we;
                  state_reg    <= OPER;
               end
            end
            OPER: begin
               alu_a      <= regfile[rdest_reg];
               alu_b      <= use_imm_reg ? imm_ext : regfile[rsrc_reg];
               alu_opcode <= opcode_reg;
               state_reg  <= EXEC;
            end
            EXEC: begin
               // Done is registered here so it is high exactly during WB.
               result_reg <= alu_c;
               flags_reg  <= alu_flags;
               done       <= 1'b1;
               state_reg  <= WB;
            end
            WB: begin
               if (flags_we_reg) begin
                  psr <= flags_reg;
               end
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed testbench for alu_exec_ctrl with an adder-based ALU stub.
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_opcode;
   logic [3:0]  req_rdest;
   logic [3:0]  req_rsrc;
   logic [7:0]  req_imm;
   logic        req_use_imm;
   logic        req_imm_sext;
   logic        req_wb_en;
   logic        req_flags_we;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [7:0]  alu_opcode;
   logic [15:0] alu_c;
   logic [4:0]  alu_flags;
   logic [4:0]  psr;
   logic        done;
   logic [3:0]  dbg_sel;
   logic [15:0] dbg_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Behavioural ALU: add, zero flag in bit 1.
   assign alu_c     = alu_a + alu_b;
   assign alu_flags = (alu_c == 16'h0000) ? 5'b00010 : 5'b00000;

   alu_exec_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_rdest(req_rdest), .req_rsrc(req_rsrc),
      .req_imm(req_imm), .req_use_imm(req_use_imm), .req_imm_sext(req_imm_sext),
      .req_wb_en(req_wb_en), .req_flags_we(req_flags_we),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_c(alu_c), .alu_flags(alu_flags),
      .psr(psr), .done(done),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   // Drive one request from a negedge; returns at the negedge of T+1.
   task automatic issue(input logic [7:0] opc, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] imm, input logic ui, input logic sx,
                        input logic wb, input logic fwe);
      req_opcode = opc; req_rdest = rd; req_rsrc = rs; req_imm = imm;
      req_use_imm = ui; req_imm_sext = sx; req_wb_en = wb; req_flags_we = fwe;
      req_valid = 1'b1;
      $display("op opc=%h rdest=%0d rsrc=%0d imm=%h use_imm=%0b sext=%0b wb=%0b fwe=%0b",
               opc, rd, rs, imm, ui, sx, wb, fwe);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // From the negedge of T+1 to the negedge of T+4.
   task automatic finish_op();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; dbg_sel = 4'h0;
      req_opcode = 8'h00; req_rdest = 4'h0; req_rsrc = 4'h0; req_imm = 8'h00;
      req_use_imm = 1'b0; req_imm_sext = 1'b0; req_wb_en = 1'b0; req_flags_we = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
      checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL reset_psr: got %b expected 00000", psr); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if ({alu_a, alu_b, alu_opcode} !== 40'h0) begin errors++; $display("FAIL reset_alu_regs: got %h/%h/%h expected 0", alu_a, alu_b, alu_opcode); end
      for (int i = 0; i < 16; i++) begin
         dbg_sel = i[3:0]; #1;
         checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_data); end
      end
   endtask

   task automatic test_imm();
      // r3 = 0 + sext(F9)
      issue(8'h5A, 4'd3, 4'd0, 8'hF9, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL imm_ready_t1: got %b expected 0", req_ready); end
      @(negedge clk); // EXEC
      checks++; if (alu_b !== 16'hFFF9) begin errors++; $display("FAIL imm_alu_b: got %h expected FFF9", alu_b); end
      checks++; if (alu_a !== 16'h0000) begin errors++; $display("FAIL imm_alu_a: got %h expected 0000", alu_a); end
      checks++; if (alu_opcode !== 8'h5A) begin errors++; $display("FAIL imm_opcode: got %h expected 5A", alu_opcode); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL imm_done_early: got %b expected 0", done); end
      @(negedge clk); // WB
      dbg_sel = 4'd3; #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL imm_done: got %b expected 1", done); end
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL imm_rbw_old: got %h expected 0000", dbg_data); end
      @(negedge clk); // T+4
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL imm_done_pulse: got %b expected 0", done); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL imm_ready_t4: got %b expected 1", req_ready); end
      checks++; if (dbg_data !== 16'hFFF9) begin errors++; $display("FAIL imm_r3: got %h expected FFF9", dbg_data); end
      checks++; if (alu_b !== 16'hFFF9) begin errors++; $display("FAIL imm_alu_b_hold: got %h expected FFF9", alu_b); end
      // r6 = 0 + zext(F9)
      issue(8'h11, 4'd6, 4'd0, 8'hF9, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (alu_b !== 16'h00F9) begin errors++; $display("FAIL zext_alu_b: got %h expected 00F9", alu_b); end
      repeat (2) @(negedge clk);
      dbg_sel = 4'd6; #1;
      checks++; if (dbg_data !== 16'h00F9) begin errors++; $display("FAIL zext_r6: got %h expected 00F9", dbg_data); end
      // r0 is an ordinary register
      issue(8'h01, 4'd0, 4'd0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
      finish_op();
      dbg_sel = 4'd0; #1;
      checks++; if (dbg_data !== 16'h0033) begin errors++; $display("FAIL r0_write: got %h expected 0033", dbg_data); end
   endtask

   task automatic test_reg_op();
      issue(8'h01, 4'd4, 4'd0, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);
      finish_op();
      dbg_sel = 4'd4; #1;
      checks++; if (dbg_data !== 16'h0005) begin errors++; $display("FAIL regop_r4_init: got %h expected 0005", dbg_data); end
      // r4 = r4 + r3 = 5 + FFF9
      issue(8'h02, 4'd4, 4'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checks++; if (alu_a !== 16'h0005) begin errors++; $display("FAIL regop_alu_a: got %h expected 0005", alu_a); end
      checks++; if (alu_b !== 16'hFFF9) begin errors++; $display("FAIL regop_alu_b: got %h expected FFF9", alu_b); end
      repeat (2) @(negedge clk);
      dbg_sel = 4'd4; #1;
      checks++; if (dbg_data !== 16'hFFFE) begin errors++; $display("FAIL regop_r4: got %h expected FFFE", dbg_data); end
      checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL regop_psr: got %b expected 00000", psr); end
   endtask

   task automatic test_compare();
      issue(8'h01, 4'd1, 4'd0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
      finish_op();
      // 7 + FFF9 wraps to zero; no write-back, flags updated
      issue(8'h03, 4'd1, 4'd0, 8'hF9, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (2) @(negedge clk); // WB
      checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL cmp_psr_before: got %b expected 00000", psr); end
      @(negedge clk);
      dbg_sel = 4'd1; #1;
      checks++; if (dbg_data !== 16'h0007) begin errors++; $display("FAIL cmp_r1: got %h expected 0007", dbg_data); end
      checks++; if (psr !== 5'b00010) begin errors++; $display("FAIL cmp_psr: got %b expected 00010", psr); end
      // Same register for both operands: r1 = 7 + 7, flags_we=0 keeps psr
      issue(8'h04, 4'd1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if ({alu_a, alu_b} !== {16'h0007, 16'h0007}) begin errors++; $display("FAIL same_ops: got %h/%h expected 0007/0007", alu_a, alu_b); end
      repeat (2) @(negedge clk);
      dbg_sel = 4'd1; #1;
      checks++; if (dbg_data !== 16'h000E) begin errors++; $display("FAIL same_r1: got %h expected 000E", dbg_data); end
      checks++; if (psr !== 5'b00010) begin errors++; $display("FAIL psr_hold: got %b expected 00010", psr); end
   endtask

   task automatic test_back_to_back();
      req_opcode = 8'h21; req_rdest = 4'd7; req_rsrc = 4'd0; req_imm = 8'h10;
      req_use_imm = 1'b1; req_imm_sext = 1'b0; req_wb_en = 1'b1; req_flags_we = 1'b0;
      req_valid = 1'b1;
      $display("op b2b first rdest=7 imm=10, second rdest=8 imm=22, valid held");
      @(posedge clk); // T: first accepted
      @(negedge clk); // T+1: switch to second request, valid stays high
      req_opcode = 8'h22; req_rdest = 4'd8; req_imm = 8'h22;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t1: got %b expected 0", req_ready); end
      @(negedge clk); // T+2
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t2: got %b expected 0", req_ready); end
      checks++; if ({alu_opcode, alu_b} !== {8'h21, 16'h0010}) begin errors++; $display("FAIL b2b_first_ops: got %h/%h expected 21/0010", alu_opcode, alu_b); end
      @(negedge clk); // T+3
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t3: got %b expected 0", req_ready); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", done); end
      @(negedge clk); // T+4: second accepted at this cycle's edge
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t4: got %b expected 1", req_ready); end
      dbg_sel = 4'd7; #1;
      checks++; if (dbg_data !== 16'h0010) begin errors++; $display("FAIL b2b_r7: got %h expected 0010", dbg_data); end
      dbg_sel = 4'd8; #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL b2b_r8_early: got %h expected 0000", dbg_data); end
      @(negedge clk); // T+5 = second OPER
      req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b expected 0", req_ready); end
      @(negedge clk);
      checks++; if ({alu_opcode, alu_b} !== {8'h22, 16'h0022}) begin errors++; $display("FAIL b2b_second_ops: got %h/%h expected 22/0022", alu_opcode, alu_b); end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", done); end
      @(negedge clk);
      dbg_sel = 4'd8; #1;
      checks++; if (dbg_data !== 16'h0022) begin errors++; $display("FAIL b2b_r8: got %h expected 0022", dbg_data); end
   endtask

   task automatic test_reset_mid_op();
      issue(8'h05, 4'd5, 4'd0, 8'h0A, 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk); // EXEC
      reset = 1'b1;
      $display("reset asserted in EXEC");
      @(negedge clk);
      reset = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", req_ready); end
      checks++; if (psr !== 5'b00000) begin errors++; $display("FAIL rmid_psr: got %b expected 00000", psr); end
      checks++; if (alu_a !== 16'h0000) begin errors++; $display("FAIL rmid_alu_a: got %h expected 0000", alu_a); end
      dbg_sel = 4'd1; #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL rmid_r1: got %h expected 0000", dbg_data); end
      dbg_sel = 4'd5;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done_c%0d: got %b expected 0", i, done); end
         checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL rmid_r5_c%0d: got %h expected 0000", i, dbg_data); end
         @(negedge clk);
      end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle: got %b expected 1", req_ready); end
   endtask

   initial begin
      test_reset();
      test_imm();
      test_reg_op();
      test_compare();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
